// File: rtl/rd_fram_buf_fill_ctrl_if.sv
// rtl/rd_fram_buf_fill_ctrl_if.sv - DDR read burst and frame buffer write bundle for the fill controller
interface rd_fram_buf_fill_ctrl_if #(
  parameter int DDR_AW = 28
) ();
  logic              ddr_req;
  logic [DDR_AW-1:0] ddr_req_addr;
  logic [7:0]        ddr_req_len;
  logic              ddr_req_ack;
  logic [255:0]      ddr_rdata;
  logic              ddr_rvalid;
  logic              ddr_rlast;
  logic [8:0]        buf_wr_addr;
  logic [255:0]      buf_wr_data;
  logic              buf_wr_en;

  // Controller side: issues bursts, receives beats, writes the buffer
  modport master (
    output ddr_req, ddr_req_addr, ddr_req_len,
    input  ddr_req_ack, ddr_rdata, ddr_rvalid, ddr_rlast,
    output buf_wr_addr, buf_wr_data, buf_wr_en
  );

  // Memory/buffer side
  modport slave (
    input  ddr_req, ddr_req_addr, ddr_req_len,
    output ddr_req_ack, ddr_rdata, ddr_rvalid, ddr_rlast,
    input  buf_wr_addr, buf_wr_data, buf_wr_en
  );
endinterface

// File: rtl/rd_fram_buf_fill_ctrl.sv
// rtl/rd_fram_buf_fill_ctrl.sv - ping-pong line fill sequencer for the read frame buffer
module rd_fram_buf_fill_ctrl #(
  parameter int                DDR_AW      = 28,
  parameter logic [DDR_AW-1:0] FRAME_BASE  = '0,
  parameter int                LINE_STRIDE = 7680,
  parameter int                LINE_BEATS  = 240,
  parameter int                BURST_LEN   = 16,
  parameter int                FRAME_LINES = 1080
) (
  input  logic                           wr_clk,
  input  logic                           wr_rst,
  input  logic                           frame_start,
  input  logic                           line_req,
  rd_fram_buf_fill_ctrl_if.master        bus,
  output logic                           fill_done,
  output logic                           fill_half,
  output logic                           busy,
  output logic                           overrun_err
);

  typedef enum logic [2:0] {IDLE, REQ, DATA, DONE, DRAIN} state_t;

  localparam int                LCW         = $clog2(FRAME_LINES + 1);
  localparam logic [LCW-1:0]    LAST_LINE   = LCW'(FRAME_LINES);
  localparam logic [DDR_AW-1:0] STRIDE      = DDR_AW'(LINE_STRIDE);
  localparam logic [DDR_AW-1:0] BURST_BYTES = DDR_AW'(BURST_LEN * 32);
  localparam logic [8:0]        LINE_BEATS9 = 9'(LINE_BEATS);
  localparam logic [8:0]        BURST_LEN9  = 9'(BURST_LEN);
  localparam int                FIRST_BEATS = (LINE_BEATS < BURST_LEN) ? LINE_BEATS : BURST_LEN;
  localparam logic [7:0]        FIRST_LEN   = 8'(FIRST_BEATS - 1);

  state_t            state;
  logic [LCW-1:0]    line_cnt;
  logic [DDR_AW-1:0] line_addr;
  logic              half;
  logic [1:0]        prefetch;
  logic              pending;
  logic [8:0]        beats_issued;
  logic [7:0]        beat_cnt;

  logic [8:0]        remaining;
  logic [8:0]        next_beats;
  logic [7:0]        next_len;
  logic              line_avail;
  logic              done_clears;
  logic              last_beat;
  logic              outstanding;

  // Length of the next burst in the current line; the tail burst takes the remainder
  always_comb begin
    remaining   = LINE_BEATS9 - beats_issued;
    next_beats  = (remaining > BURST_LEN9) ? BURST_LEN9 : remaining;
    next_len    = 8'(next_beats - 9'd1);
    line_avail  = (line_cnt < LAST_LINE);
    done_clears = (state == DONE) && (prefetch == 2'd0);
    last_beat   = bus.ddr_rvalid && bus.ddr_rlast;
    outstanding = ((state == REQ) && bus.ddr_req_ack) ||
                  (((state == DATA) || (state == DRAIN)) && !last_beat);
  end

  assign busy = (state != IDLE);

  // Fill sequencer: burst issue, beat write-back, line bookkeeping and frame restart
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      state            <= IDLE;
      line_cnt         <= '0;
      line_addr        <= FRAME_BASE;
      half             <= 1'b0;
      prefetch         <= 2'd0;
      pending          <= 1'b0;
      beats_issued     <= '0;
      beat_cnt         <= '0;
      fill_done        <= 1'b0;
      fill_half        <= 1'b0;
      overrun_err      <= 1'b0;
      bus.ddr_req      <= 1'b0;
      bus.ddr_req_addr <= '0;
      bus.ddr_req_len  <= '0;
      bus.buf_wr_en    <= 1'b0;
      bus.buf_wr_addr  <= '0;
      bus.buf_wr_data  <= '0;
    end else begin
      fill_done     <= 1'b0;
      bus.buf_wr_en <= 1'b0;

      case (state)
        IDLE: begin
          if (((prefetch != 2'd0) || pending) && line_avail) begin
            beats_issued     <= '0;
            beat_cnt         <= '0;
            bus.ddr_req      <= 1'b1;
            bus.ddr_req_addr <= line_addr;
            bus.ddr_req_len  <= FIRST_LEN;
            state            <= REQ;
          end
        end
        REQ: begin
          if (bus.ddr_req_ack) begin
            bus.ddr_req  <= 1'b0;
            beats_issued <= beats_issued + 9'(bus.ddr_req_len) + 9'd1;
            state        <= DATA;
          end
        end
        DATA: begin
          if (bus.ddr_rvalid) begin
            bus.buf_wr_en   <= 1'b1;
            bus.buf_wr_addr <= {half, beat_cnt};
            bus.buf_wr_data <= bus.ddr_rdata;
            beat_cnt        <= beat_cnt + 8'd1;
            if (bus.ddr_rlast) begin
              if (beats_issued < LINE_BEATS9) begin
                bus.ddr_req      <= 1'b1;
                bus.ddr_req_addr <= bus.ddr_req_addr + BURST_BYTES;
                bus.ddr_req_len  <= next_len;
                state            <= REQ;
              end else begin
                state <= DONE;
              end
            end
          end
        end
        DONE: begin
          fill_done <= 1'b1;
          fill_half <= half;
          half      <= ~half;
          line_cnt  <= line_cnt + 1'b1;
          line_addr <= line_addr + STRIDE;
          if (prefetch != 2'd0) prefetch <= prefetch - 2'd1;
          else                  pending  <= 1'b0;
          state     <= IDLE;
        end
        DRAIN: begin
          if (last_beat) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A display request queues one refill; a second before it is served is dropped
      if (line_req && line_avail) begin
        if (pending && !done_clears) overrun_err <= 1'b1;
        else                         pending     <= 1'b1;
      end

      // Frame restart overrides everything; an in-flight burst is drained, not written
      if (frame_start) begin
        line_cnt      <= '0;
        line_addr     <= FRAME_BASE;
        half          <= 1'b0;
        prefetch      <= 2'd2;
        pending       <= 1'b0;
        overrun_err   <= 1'b0;
        fill_done     <= 1'b0;
        bus.ddr_req   <= 1'b0;
        bus.buf_wr_en <= 1'b0;
        state         <= outstanding ? DRAIN : IDLE;
      end
    end
  end

endmodule
